tdt_dtm_apb_mst: RTL and testbench
==================================

TDT_DTM_APB_MST -- requirements
Module: tdt_dtm_apb_mst

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYC, default 255, max APB access-phase cycles before abort (range 2..255, 8-bit counter).
REQ-002 SHALL use one clock and a synchronous, active-low reset, as listed first below.
REQ-003 Port list (name, direction, width, meaning):
- sys_apb_clk  in  1  sole clock.
- sys_apb_rst_b  in  1  synchronous active-low reset.
- dtm_dmi_req_vld  in  1  DMI request valid.
- dtm_dmi_req_op  in  2  0 nop, 1 read, 2 write, 3 reserved.
- dtm_dmi_req_addr  in  7  DMI register word address.
- dtm_dmi_req_data  in  32  write data.
- dmi_dtm_req_rdy  out  1  request accepted when vld&rdy.
- dmi_dtm_rsp_vld  out  1  response valid.
- dmi_dtm_rsp_op  out  2  0 success, 2 failed.
- dmi_dtm_rsp_data  out  32  read data.
- dtm_dmi_rsp_rdy  in  1  response consumed when vld&rdy.
- dtm_dmi_reset  in  1  pulse; clears sticky error.
- dmi_dtm_err_sticky  out  1  sticky failure flag.
- tdt_dmi_paddr  out  12  APB address.
- tdt_dmi_psel, tdt_dmi_penable, tdt_dmi_pwrite  out  1 each  APB control.
- tdt_dmi_pwdata  out  32  APB write data.
- tdt_dmi_prdata  in  32; tdt_dmi_pready, tdt_dmi_pslverr  in  1 each  APB completion.

Function
REQ-004 All outputs SHALL be registered; no combinational input-to-output path.
REQ-005 FSM states SHALL be IDLE, SETUP, ACCESS, RESP.
REQ-006 dmi_dtm_req_rdy SHALL be 1 only in IDLE.
REQ-007 Acceptance in IDLE for op 1/2 with sticky clear SHALL latch addr/data/op and go to SETUP.
REQ-008 tdt_dmi_paddr SHALL equal {3'b000, addr, 2'b00}; pwrite SHALL be 1 for op 2, 0 otherwise; pwdata SHALL be req data for writes, 0 for reads.
REQ-009 SETUP SHALL drive psel=1, penable=0 for exactly one cycle, then go to ACCESS.
REQ-010 ACCESS SHALL drive psel=1, penable=1; address, control and wdata SHALL stay stable from SETUP until the access ends.
REQ-011 ACCESS with pready=1 SHALL go to RESP.
- rsp_op = pslverr ? 2 : 0.
- rsp_data = prdata for reads with pslverr=0; 0 otherwise.
- pslverr=1 SHALL set the sticky error.
REQ-012 Timeout counter:
- cleared on entering ACCESS; increments each ACCESS cycle with pready=0.
- If the count reaches TIMEOUT_CYC-1 with pready=0, the block SHALL end the access (psel/penable=0 next cycle), return rsp_op=2 and data 0, set sticky, and go to RESP.
- pready=1 in that same cycle SHALL count as normal completion.
REQ-013 Op 0 (nop) accepted SHALL go directly to RESP with rsp_op = sticky ? 2 : 0, data 0, and no APB transfer.
REQ-014 Op 3 accepted SHALL go directly to RESP with rsp_op=2, set sticky, and perform no APB transfer.
REQ-015 Op 1/2 accepted with sticky=1 SHALL go directly to RESP with rsp_op=2, data 0, and perform no APB transfer.
REQ-016 RESP SHALL hold rsp_vld=1 with stable op/data until dtm_dmi_rsp_rdy=1, then go to IDLE; req_rdy SHALL rise the cycle after the handshake.
REQ-017 Latency, with accept at cycle T and pready=1 at first ACCESS cycle: psel at T+1, penable at T+2, rsp_vld at T+3. Minimum accept-to-accept spacing SHALL be 4 cycles for APB ops and 2 cycles for short-circuited ops, when rsp_rdy is held high.
REQ-018 dtm_dmi_reset SHALL clear sticky the next cycle in any state. If it coincides with a sticky-set event, clear SHALL win. It SHALL NOT abort an in-flight transfer or response.
REQ-019 In ACCESS, psel SHALL never drop before pready=1 or timeout.

Reset
REQ-020 When sys_apb_rst_b=0 at a clock edge, the next state SHALL be:
- FSM = IDLE, sticky = 0, timeout counter = 0.
- psel, penable, pwrite = 0; paddr, pwdata = 0.
- req_rdy = 1, rsp_vld = 0, rsp_op = 0, rsp_data = 0.
REQ-021 Reset asserted mid-transfer SHALL abandon the transfer and the pending response without emitting rsp_vld.

Verification
REQ-022 Read addr 0x11, pready on first ACCESS cycle, prdata=0xDEADBEEF -> paddr=0x044, rsp_vld at T+3, rsp_op=0, data=0xDEADBEEF.
REQ-023 Write addr 0x10, data 0x80000001, pready after 3 wait cycles -> pwrite=1, pwdata stable for 5 cycles, rsp_op=0, rsp_vld at T+6.
REQ-024 Read with pslverr=1 -> rsp_op=2, sticky=1; next read -> rsp_op=2 with psel never asserted; dtm_dmi_reset pulse then read -> APB transfer occurs, rsp_op=0.
REQ-025 TIMEOUT_CYC=4, pready held 0 -> psel drops after 4 ACCESS cycles, rsp_op=2, data 0, sticky=1.
REQ-026 rsp_rdy held 0 for 10 cycles -> rsp_vld/op/data stable and req_rdy=0 throughout; handshake -> req_rdy=1 next cycle.
REQ-027 Reset asserted during ACCESS -> next cycle psel=0, rsp_vld=0, req_rdy=1, sticky=0.

Source files
------------

// File: rtl/tdt_dtm_apb_mst_if.sv
// Bundle of the DMI request/response channel, the sticky-error controls and
// the APB master bus used by tdt_dtm_apb_mst.
//   master : the bridge side (drives req_rdy, rsp_*, err_sticky, APB requests)
//   slave  : the environment side (DTM requester plus APB completer)
interface tdt_dtm_apb_mst_if;
  // DMI request channel
  logic        dtm_dmi_req_vld;
  logic [1:0]  dtm_dmi_req_op;
  logic [6:0]  dtm_dmi_req_addr;
  logic [31:0] dtm_dmi_req_data;
  logic        dmi_dtm_req_rdy;
  // DMI response channel
  logic        dmi_dtm_rsp_vld;
  logic [1:0]  dmi_dtm_rsp_op;
  logic [31:0] dmi_dtm_rsp_data;
  logic        dtm_dmi_rsp_rdy;
  // Sticky error control
  logic        dtm_dmi_reset;
  logic        dmi_dtm_err_sticky;
  // APB master
  logic [11:0] tdt_dmi_paddr;
  logic        tdt_dmi_psel;
  logic        tdt_dmi_penable;
  logic        tdt_dmi_pwrite;
  logic [31:0] tdt_dmi_pwdata;
  logic [31:0] tdt_dmi_prdata;
  logic        tdt_dmi_pready;
  logic        tdt_dmi_pslverr;

  modport master (
    input  dtm_dmi_req_vld, dtm_dmi_req_op, dtm_dmi_req_addr, dtm_dmi_req_data,
    output dmi_dtm_req_rdy,
    output dmi_dtm_rsp_vld, dmi_dtm_rsp_op, dmi_dtm_rsp_data,
    input  dtm_dmi_rsp_rdy,
    input  dtm_dmi_reset,
    output dmi_dtm_err_sticky,
    output tdt_dmi_paddr, tdt_dmi_psel, tdt_dmi_penable, tdt_dmi_pwrite, tdt_dmi_pwdata,
    input  tdt_dmi_prdata, tdt_dmi_pready, tdt_dmi_pslverr
  );

  modport slave (
    output dtm_dmi_req_vld, dtm_dmi_req_op, dtm_dmi_req_addr, dtm_dmi_req_data,
    input  dmi_dtm_req_rdy,
    input  dmi_dtm_rsp_vld, dmi_dtm_rsp_op, dmi_dtm_rsp_data,
    output dtm_dmi_rsp_rdy,
    output dtm_dmi_reset,
    input  dmi_dtm_err_sticky,
    input  tdt_dmi_paddr, tdt_dmi_psel, tdt_dmi_penable, tdt_dmi_pwrite, tdt_dmi_pwdata,
    output tdt_dmi_prdata, tdt_dmi_pready, tdt_dmi_pslverr
  );
endinterface

// File: rtl/tdt_dtm_apb_mst.sv
// DMI-to-APB bridge: accepts one DMI request at a time, runs it as an APB
// transfer (with access-phase timeout), and returns a DMI response.
// Failures set a sticky error that short-circuits later reads/writes until
// cleared by dtm_dmi_reset.
// Ports:
//   sys_apb_clk   - sole clock
//   sys_apb_rst_b - synchronous active-low reset
//   bus           - tdt_dtm_apb_mst_if.master (DMI req/rsp, sticky, APB)
module tdt_dtm_apb_mst #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input logic                sys_apb_clk,
  input logic                sys_apb_rst_b,
  tdt_dtm_apb_mst_if.master  bus
);

  localparam logic [1:0] OP_NOP  = 2'd0;
  localparam logic [1:0] OP_RD   = 2'd1;
  localparam logic [1:0] OP_WR   = 2'd2;
  localparam logic [1:0] RSP_OK  = 2'd0;
  localparam logic [1:0] RSP_ERR = 2'd2;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t     state;
  logic [7:0] to_cnt;

  // Single registered FSM; every output is a flop updated here.
  always_ff @(posedge sys_apb_clk) begin
    if (!sys_apb_rst_b) begin
      state                  <= IDLE;
      to_cnt                 <= 8'd0;
      bus.dmi_dtm_err_sticky <= 1'b0;
      bus.dmi_dtm_req_rdy    <= 1'b1;
      bus.dmi_dtm_rsp_vld    <= 1'b0;
      bus.dmi_dtm_rsp_op     <= RSP_OK;
      bus.dmi_dtm_rsp_data   <= 32'd0;
      bus.tdt_dmi_paddr      <= 12'd0;
      bus.tdt_dmi_psel       <= 1'b0;
      bus.tdt_dmi_penable    <= 1'b0;
      bus.tdt_dmi_pwrite     <= 1'b0;
      bus.tdt_dmi_pwdata     <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.dtm_dmi_req_vld) begin
            bus.dmi_dtm_req_rdy <= 1'b0;
            if ((bus.dtm_dmi_req_op == OP_RD || bus.dtm_dmi_req_op == OP_WR) &&
                !bus.dmi_dtm_err_sticky) begin
              state               <= SETUP;
              bus.tdt_dmi_psel    <= 1'b1;
              bus.tdt_dmi_penable <= 1'b0;
              bus.tdt_dmi_paddr   <= {3'b000, bus.dtm_dmi_req_addr, 2'b00};
              bus.tdt_dmi_pwrite  <= (bus.dtm_dmi_req_op == OP_WR);
              bus.tdt_dmi_pwdata  <= (bus.dtm_dmi_req_op == OP_WR) ? bus.dtm_dmi_req_data : 32'd0;
            end else begin
              // Short-circuit: nop reports the sticky state, everything else fails.
              state                <= RESP;
              bus.dmi_dtm_rsp_vld  <= 1'b1;
              bus.dmi_dtm_rsp_data <= 32'd0;
              if (bus.dtm_dmi_req_op == OP_NOP) begin
                bus.dmi_dtm_rsp_op <= bus.dmi_dtm_err_sticky ? RSP_ERR : RSP_OK;
              end else begin
                bus.dmi_dtm_rsp_op <= RSP_ERR;
              end
              if (bus.dtm_dmi_req_op == 2'd3) begin
                bus.dmi_dtm_err_sticky <= 1'b1;
              end
            end
          end
        end
        SETUP: begin
          state               <= ACCESS;
          bus.tdt_dmi_penable <= 1'b1;
          to_cnt              <= 8'd0;
        end
        ACCESS: begin
          // pready wins over a timeout landing in the same cycle.
          if (bus.tdt_dmi_pready) begin
            state                <= RESP;
            bus.tdt_dmi_psel     <= 1'b0;
            bus.tdt_dmi_penable  <= 1'b0;
            bus.dmi_dtm_rsp_vld  <= 1'b1;
            bus.dmi_dtm_rsp_op   <= bus.tdt_dmi_pslverr ? RSP_ERR : RSP_OK;
            bus.dmi_dtm_rsp_data <= (!bus.tdt_dmi_pwrite && !bus.tdt_dmi_pslverr) ?
                                    bus.tdt_dmi_prdata : 32'd0;
            if (bus.tdt_dmi_pslverr) begin
              bus.dmi_dtm_err_sticky <= 1'b1;
            end
          end else if (to_cnt == TO_LAST) begin
            state                  <= RESP;
            bus.tdt_dmi_psel       <= 1'b0;
            bus.tdt_dmi_penable    <= 1'b0;
            bus.dmi_dtm_rsp_vld    <= 1'b1;
            bus.dmi_dtm_rsp_op     <= RSP_ERR;
            bus.dmi_dtm_rsp_data   <= 32'd0;
            bus.dmi_dtm_err_sticky <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        RESP: begin
          if (bus.dtm_dmi_rsp_rdy) begin
            state               <= IDLE;
            bus.dmi_dtm_rsp_vld <= 1'b0;
            bus.dmi_dtm_req_rdy <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      // Clear request overrides any set in the same cycle.
      if (bus.dtm_dmi_reset) begin
        bus.dmi_dtm_err_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tdt_dtm_apb_mst.sv
// Bench for tdt_dtm_apb_mst: directed vector table, reset sequences, and
// randomized transactions checked against a transaction-level model.
module tb_tdt_dtm_apb_mst;

  localparam int TIMEOUT = 4;

  logic clk;
  logic rst_b;
  int   total;
  int   bad;
  bit   msticky;

  tdt_dtm_apb_mst_if bus ();

  tdt_dtm_apb_mst #(.TIMEOUT_CYC(TIMEOUT)) dut (
    .sys_apb_clk   (clk),
    .sys_apb_rst_b (rst_b),
    .bus           (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [6:0]  addr;
    logic [31:0] data;
    int          waits;   // ACCESS cycles with pready=0 before completion
    bit          slverr;
    logic [31:0] prdata;
    int          rspdly;  // cycles rsp_rdy stays low after rsp_vld
    bit          clr;     // dtm_dmi_reset in the deciding cycle
    bit          pre_clr; // dtm_dmi_reset pulse before the request
  } vec_t;

  typedef struct {
    bit          apb;
    logic [11:0] paddr;
    bit          pwrite;
    logic [31:0] pwdata;
    int          acc;
    int          lat;
    logic [1:0]  op;
    logic [31:0] data;
    bit          sticky;
  } exp_t;

  typedef struct {
    vec_t v;
    exp_t e;
  } row_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                               input int waits, input bit slverr, input logic [31:0] prdata,
                               input int rspdly, input bit clr, input bit pre_clr);
    vec_t v;
    v.op = op; v.addr = addr; v.data = data; v.waits = waits; v.slverr = slverr;
    v.prdata = prdata; v.rspdly = rspdly; v.clr = clr; v.pre_clr = pre_clr;
    return v;
  endfunction

  function automatic exp_t mke(input bit apb, input logic [11:0] paddr, input bit pwrite,
                               input logic [31:0] pwdata, input int acc, input int lat,
                               input logic [1:0] op, input logic [31:0] data, input bit sticky);
    exp_t e;
    e.apb = apb; e.paddr = paddr; e.pwrite = pwrite; e.pwdata = pwdata; e.acc = acc;
    e.lat = lat; e.op = op; e.data = data; e.sticky = sticky;
    return e;
  endfunction

  // Transaction-level reference: outcome of one request given the sticky flag.
  function automatic exp_t model(input vec_t v, input bit st_in);
    exp_t e;
    bit   st;
    bit   set;
    st = v.pre_clr ? 1'b0 : st_in;
    e = mke(0, 12'h0, 0, 32'h0, 0, 1, 2'd2, 32'h0, 0);
    set = 0;
    if ((v.op == 2'd1 || v.op == 2'd2) && !st) begin
      e.apb    = 1;
      e.paddr  = 12'(v.addr) * 12'd4;
      e.pwrite = (v.op == 2'd2);
      e.pwdata = e.pwrite ? v.data : 32'h0;
      if (v.waits + 1 <= TIMEOUT) begin
        e.acc  = v.waits + 1;
        e.op   = v.slverr ? 2'd2 : 2'd0;
        e.data = (!e.pwrite && !v.slverr) ? v.prdata : 32'h0;
        set    = v.slverr;
      end else begin
        e.acc = TIMEOUT;
        set   = 1;
      end
      e.lat = 2 + e.acc;
    end else begin
      e.op = (v.op == 2'd0 && !st) ? 2'd0 : 2'd2;
      set  = (v.op == 2'd3);
    end
    e.sticky = v.clr ? 1'b0 : (st | set);
    return e;
  endfunction

  // Runs one request end to end, acting as requester and APB completer.
  task automatic run_txn(input vec_t v, input exp_t e, input string tag);
    int cyc, acc, setup_n, lat, hs_cyc, dec;
    bit apb_seen, unstable, rdy_bad, done;
    logic [11:0] pa;
    logic        pw;
    logic [31:0] pd, rdat;
    logic [1:0]  rop;
    if (v.pre_clr) begin
      bus.dtm_dmi_reset = 1'b1;
      @(negedge clk);
      bus.dtm_dmi_reset = 1'b0;
      check({tag, "_preclr_sticky"}, 32'(bus.dmi_dtm_err_sticky), 32'd0);
    end
    check({tag, "_req_rdy_idle"}, 32'(bus.dmi_dtm_req_rdy), 32'd1);
    bus.dtm_dmi_req_vld  = 1'b1;
    bus.dtm_dmi_req_op   = v.op;
    bus.dtm_dmi_req_addr = v.addr;
    bus.dtm_dmi_req_data = v.data;
    if (v.clr && !e.apb) bus.dtm_dmi_reset = 1'b1;
    dec = (v.waits + 1 < TIMEOUT) ? v.waits + 1 : TIMEOUT;
    cyc = 0; acc = 0; setup_n = 0; lat = -1; hs_cyc = -1;
    apb_seen = 0; unstable = 0; rdy_bad = 0; done = 0;
    pa = '0; pw = 0; pd = '0; rdat = '0; rop = '0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      bus.dtm_dmi_req_vld = 1'b0;
      bus.dtm_dmi_reset   = 1'b0;
      bus.tdt_dmi_pready  = 1'b0;
      bus.tdt_dmi_pslverr = 1'b0;
      bus.tdt_dmi_prdata  = $urandom;
      if (hs_cyc >= 0) begin
        check({tag, "_req_rdy_after_hs"}, 32'(bus.dmi_dtm_req_rdy), 32'd1);
        check({tag, "_rsp_vld_after_hs"}, 32'(bus.dmi_dtm_rsp_vld), 32'd0);
        bus.dtm_dmi_rsp_rdy = 1'b0;
        done = 1;
      end else begin
        if (bus.dmi_dtm_req_rdy) rdy_bad = 1;
        if (bus.tdt_dmi_psel) begin
          if (!apb_seen) begin
            pa = bus.tdt_dmi_paddr; pw = bus.tdt_dmi_pwrite; pd = bus.tdt_dmi_pwdata;
            apb_seen = 1;
          end else if (pa !== bus.tdt_dmi_paddr || pw !== bus.tdt_dmi_pwrite ||
                       pd !== bus.tdt_dmi_pwdata) begin
            unstable = 1;
          end
          if (!bus.tdt_dmi_penable) setup_n++;
          else begin
            acc++;
            if (acc == v.waits + 1) begin
              bus.tdt_dmi_pready  = 1'b1;
              bus.tdt_dmi_pslverr = v.slverr;
              bus.tdt_dmi_prdata  = v.prdata;
            end
            if (v.clr && acc == dec) bus.dtm_dmi_reset = 1'b1;
          end
        end
        if (bus.dmi_dtm_rsp_vld) begin
          if (lat < 0) begin
            lat = cyc; rop = bus.dmi_dtm_rsp_op; rdat = bus.dmi_dtm_rsp_data;
          end else if (rop !== bus.dmi_dtm_rsp_op || rdat !== bus.dmi_dtm_rsp_data) begin
            unstable = 1;
          end
          if (cyc - lat == v.rspdly) begin
            bus.dtm_dmi_rsp_rdy = 1'b1;
            hs_cyc = cyc;
          end
        end
      end
    end
    bus.dtm_dmi_rsp_rdy = 1'b0;
    check({tag, "_completed"}, 32'(done), 32'd1);
    check({tag, "_apb_seen"}, 32'(apb_seen), 32'(e.apb));
    if (e.apb) begin
      check({tag, "_paddr"}, 32'(pa), 32'(e.paddr));
      check({tag, "_pwrite"}, 32'(pw), 32'(e.pwrite));
      check({tag, "_pwdata"}, pd, e.pwdata);
      check({tag, "_setup_cycles"}, 32'(setup_n), 32'd1);
      check({tag, "_access_cycles"}, 32'(acc), 32'(e.acc));
    end
    check({tag, "_rsp_latency"}, 32'(lat), 32'(e.lat));
    check({tag, "_rsp_op"}, 32'(rop), 32'(e.op));
    check({tag, "_rsp_data"}, rdat, e.data);
    check({tag, "_stable"}, 32'(unstable), 32'd0);
    check({tag, "_req_rdy_low_busy"}, 32'(rdy_bad), 32'd0);
    check({tag, "_sticky"}, 32'(bus.dmi_dtm_err_sticky), 32'(e.sticky));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req_rdy"}, 32'(bus.dmi_dtm_req_rdy), 32'd1);
    check({tag, "_rsp_vld"}, 32'(bus.dmi_dtm_rsp_vld), 32'd0);
    check({tag, "_psel"}, 32'(bus.tdt_dmi_psel), 32'd0);
    check({tag, "_penable"}, 32'(bus.tdt_dmi_penable), 32'd0);
    check({tag, "_sticky"}, 32'(bus.dmi_dtm_err_sticky), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  row_t tbl[13];

  initial begin
    vec_t v;
    exp_t e;
    int   quiet;
    total = 0; bad = 0; msticky = 0;
    rst_b = 1'b0;
    bus.dtm_dmi_req_vld = 0; bus.dtm_dmi_req_op = 0; bus.dtm_dmi_req_addr = 0;
    bus.dtm_dmi_req_data = 0; bus.dtm_dmi_rsp_rdy = 0; bus.dtm_dmi_reset = 0;
    bus.tdt_dmi_prdata = 0; bus.tdt_dmi_pready = 0; bus.tdt_dmi_pslverr = 0;

    //              op    addr   data          wt slv prdata        dly clr pre
    tbl[0].v  = mkv(2'd1, 7'h11, 32'h0,        0, 0, 32'hDEADBEEF, 0,  0,  0);
    tbl[0].e  = mke(1, 12'h044, 0, 32'h0,        1, 3, 2'd0, 32'hDEADBEEF, 0);
    tbl[1].v  = mkv(2'd2, 7'h10, 32'h80000001, 3, 0, 32'h0,        0,  0,  0);
    tbl[1].e  = mke(1, 12'h040, 1, 32'h80000001, 4, 6, 2'd0, 32'h0, 0);
    tbl[2].v  = mkv(2'd1, 7'h05, 32'h0,        1, 1, 32'h12345678, 0,  0,  0);
    tbl[2].e  = mke(1, 12'h014, 0, 32'h0,        2, 4, 2'd2, 32'h0, 1);
    tbl[3].v  = mkv(2'd1, 7'h06, 32'h0,        0, 0, 32'h11111111, 0,  0,  0);
    tbl[3].e  = mke(0, 12'h0,   0, 32'h0,        0, 1, 2'd2, 32'h0, 1);
    tbl[4].v  = mkv(2'd0, 7'h00, 32'h0,        0, 0, 32'h0,        0,  0,  0);
    tbl[4].e  = mke(0, 12'h0,   0, 32'h0,        0, 1, 2'd2, 32'h0, 1);
    tbl[5].v  = mkv(2'd1, 7'h06, 32'h0,        0, 0, 32'hCAFEF00D, 0,  0,  1);
    tbl[5].e  = mke(1, 12'h018, 0, 32'h0,        1, 3, 2'd0, 32'hCAFEF00D, 0);
    tbl[6].v  = mkv(2'd0, 7'h00, 32'h0,        0, 0, 32'h0,        0,  0,  0);
    tbl[6].e  = mke(0, 12'h0,   0, 32'h0,        0, 1, 2'd0, 32'h0, 0);
    tbl[7].v  = mkv(2'd3, 7'h01, 32'h0,        0, 0, 32'h0,        0,  0,  0);
    tbl[7].e  = mke(0, 12'h0,   0, 32'h0,        0, 1, 2'd2, 32'h0, 1);
    tbl[8].v  = mkv(2'd2, 7'h7F, 32'hA5A5A5A5, 4, 0, 32'h0,        0,  0,  1);
    tbl[8].e  = mke(1, 12'h1FC, 1, 32'hA5A5A5A5, 4, 6, 2'd2, 32'h0, 1);
    tbl[9].v  = mkv(2'd1, 7'h00, 32'h0,        2, 0, 32'h0000FFFF, 10, 0,  1);
    tbl[9].e  = mke(1, 12'h000, 0, 32'h0,        3, 5, 2'd0, 32'h0000FFFF, 0);
    tbl[10].v = mkv(2'd1, 7'h01, 32'h0,        0, 1, 32'h0,        0,  1,  1);
    tbl[10].e = mke(1, 12'h004, 0, 32'h0,        1, 3, 2'd2, 32'h0, 0);
    tbl[11].v = mkv(2'd3, 7'h00, 32'h0,        0, 0, 32'h0,        0,  1,  0);
    tbl[11].e = mke(0, 12'h0,   0, 32'h0,        0, 1, 2'd2, 32'h0, 0);
    tbl[12].v = mkv(2'd2, 7'h02, 32'h00000001, 0, 1, 32'h0,        0,  0,  0);
    tbl[12].e = mke(1, 12'h008, 1, 32'h00000001, 1, 3, 2'd2, 32'h0, 1);

    // Power-on reset.
    repeat (3) @(negedge clk);
    check_reset_state("por");
    check("por_pwrite", 32'(bus.tdt_dmi_pwrite), 32'd0);
    check("por_paddr", 32'(bus.tdt_dmi_paddr), 32'd0);
    check("por_pwdata", bus.tdt_dmi_pwdata, 32'd0);
    check("por_rsp_op", 32'(bus.dmi_dtm_rsp_op), 32'd0);
    check("por_rsp_data", bus.dmi_dtm_rsp_data, 32'd0);
    rst_b = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      run_txn(tbl[i].v, tbl[i].e, $sformatf("vec%0d", i));
    end

    // Reset while a response is pending with sticky set.
    bus.dtm_dmi_req_vld = 1'b1; bus.dtm_dmi_req_op = 2'd3;
    @(negedge clk);
    bus.dtm_dmi_req_vld = 1'b0;
    check("rstresp_rsp_vld_pre", 32'(bus.dmi_dtm_rsp_vld), 32'd1);
    check("rstresp_sticky_pre", 32'(bus.dmi_dtm_err_sticky), 32'd1);
    rst_b = 1'b0;
    @(negedge clk);
    check_reset_state("rstresp");
    rst_b = 1'b1;
    @(negedge clk);

    // Reset during ACCESS abandons the transfer.
    bus.dtm_dmi_req_vld = 1'b1; bus.dtm_dmi_req_op = 2'd1; bus.dtm_dmi_req_addr = 7'h03;
    @(negedge clk);
    bus.dtm_dmi_req_vld = 1'b0;
    check("rstacc_setup_psel", 32'(bus.tdt_dmi_psel), 32'd1);
    @(negedge clk);
    check("rstacc_access_penable", 32'(bus.tdt_dmi_penable), 32'd1);
    rst_b = 1'b0;
    @(negedge clk);
    check_reset_state("rstacc");
    rst_b = 1'b1;
    quiet = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.dmi_dtm_rsp_vld || bus.tdt_dmi_psel) quiet++;
    end
    check("rstacc_no_late_activity", 32'(quiet), 32'd0);
    msticky = 0;

    // Randomized transactions against the model.
    for (int n = 0; n < 80; n++) begin
      v = mkv(2'($urandom_range(0, 3)), 7'($urandom), $urandom, $urandom_range(0, 6),
              ($urandom_range(0, 5) == 0), $urandom, $urandom_range(0, 3),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
      e = model(v, msticky);
      msticky = e.sticky;
      run_txn(v, e, $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
